// File: rtl/ring_monitor.sv
// Monitors an 8-bit one-hot ring counter: decodes its position, flags illegal and out-of-sequence
// values, detects wrap, and tracks lock. Optional RING_MON_CLR_EN adds an err_clr input for err_count.
module ring_monitor #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ring,
`ifdef RING_MON_CLR_EN
  input  logic       err_clr,
`endif
  output logic [2:0] index,
  output logic       valid,
  output logic       illegal,
  output logic       seq_err,
  output logic       wrap,
  output logic       locked,
  output logic [7:0] err_count
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_RUN = LOCK_CNT[3:0];

  state_t     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [7:0] prev_ring;
  logic       prev_en;
  logic       prev_ok;

  logic [7:0] expected;
  logic       sample_ok;
  logic       in_seq;
  logic       illegal_c;
  logic       seq_err_c;
  logic       wrap_c;
  logic       error_c;
  logic [7:0] err_d;

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] pos;
    pos = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) pos = 3'(i);
    end
    return pos;
  endfunction

  // Classify the current sample against what the previous sample predicts.
  assign sample_ok = (ring != 8'h00) && ((ring & (ring - 8'h01)) == 8'h00);
  assign expected  = prev_en ? {prev_ring[6:0], prev_ring[7]} : prev_ring;
  assign in_seq    = sample_ok && prev_ok && (ring == expected);
  assign illegal_c = !sample_ok;
  assign seq_err_c = sample_ok && prev_ok && (ring != expected);
  assign wrap_c    = prev_ok && prev_en && (prev_ring == 8'h80) && (ring == 8'h01);
  assign error_c   = illegal_c || seq_err_c;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      HUNT: begin
        if (in_seq) begin
          if (run_q + 4'd1 == LOCK_RUN) begin
            state_d = LOCKED;
            run_d   = 4'd0;
          end else begin
            run_d = run_q + 4'd1;
          end
        end else begin
          run_d = 4'd0;
        end
      end
      LOCKED: begin
        if (error_c) begin
          state_d = HUNT;
          run_d   = 4'd0;
        end
      end
      default: begin
        state_d = HUNT;
        run_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    err_d = err_count;
    if (error_c && (err_count != 8'hFF)) err_d = err_count + 8'd1;
`ifdef RING_MON_CLR_EN
    // A clear coinciding with an error still records that error.
    if (err_clr) err_d = error_c ? 8'd1 : 8'd0;
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HUNT;
      run_q     <= 4'd0;
      prev_ring <= 8'h00;
      prev_en   <= 1'b0;
      prev_ok   <= 1'b0;
      index     <= 3'd0;
      valid     <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_count <= 8'h00;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      prev_ring <= ring;
      prev_en   <= enable;
      prev_ok   <= sample_ok;
      if (sample_ok) index <= encode(ring);
      valid     <= sample_ok;
      illegal   <= illegal_c;
      seq_err   <= seq_err_c;
      wrap      <= wrap_c;
      err_count <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
